// File: rtl/fp_pkg.sv
// Shared types and field positions for the FP adder
// normalize/round/pack stage.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int MANT_W     = FRAC_W + 4;
  localparam int CARRY_BIT  = 26;
  localparam int HIDDEN_BIT = 25;
  localparam int FRAC_MSB   = 24;
  localparam int FRAC_LSB   = 2;
  localparam int GUARD_BIT  = 1;
  localparam int STICKY_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] fraction;
  } fp32_t;

endpackage

// File: rtl/fp_round.sv
// Round-to-nearest-even increment on a normalized
// or subnormal mantissa, with exponent fix-up.
module fp_round
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              ovf
);

  logic              up;
  logic [MANT_W-3:0] sum;
  logic [EXP_W-1:0]  exp_inc;

  assign up = mant[GUARD_BIT]
            & (mant[STICKY_BIT] | mant[FRAC_LSB]);

  assign sum = mant[CARRY_BIT:FRAC_LSB]
             + {{(MANT_W-3){1'b0}}, up};

  assign exp_inc = exp + 1'b1;

  always_comb begin
    frac_out = sum[FRAC_W-1:0];
    exp_out  = exp;
    ovf      = 1'b0;
    if (sum[MANT_W-3]) begin
      // increment rippled into the carry bit
      frac_out = sum[FRAC_W:1];
      exp_out  = exp_inc;
      if (exp_inc == EXP_MAX) begin
        ovf      = 1'b1;
        frac_out = '0;
      end
    end else if (exp == '0 && sum[FRAC_W]) begin
      exp_out = {{(EXP_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fp_normalizer.sv
// Normalize / round / pack stage of the FP adder:
// iterative shift FSM, RNE rounding, IEEE-754 packing.
module fp_normalizer #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic                   signIn,
  input  logic [EXP_W-1:0]       exponentIn,
  input  logic [FRAC_W+3:0]      mantissaIn,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [EXP_W+FRAC_W:0]  result,
  output logic                   overflow,
  output logic                   zero
);

  import fp_pkg::norm_state_t;
  import fp_pkg::fp32_t;
  import fp_pkg::IDLE;
  import fp_pkg::NORM;
  import fp_pkg::ROUND;
  import fp_pkg::DONE;

  localparam int MW = FRAC_W + 4;
  localparam int CB = MW - 1;
  localparam int HB = MW - 2;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EONE = 1;
  localparam logic [FRAC_W-1:0] FZERO = '0;

  norm_state_t state;
  fp32_t       res_q;

  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MW-1:0]     mant_q;
  logic [EXP_W-1:0]  exp_inc;

  logic [FRAC_W-1:0] in_frac;
  logic [FRAC_W-1:0] nan_frac;

  logic [FRAC_W-1:0] rnd_frac;
  logic [EXP_W-1:0]  rnd_exp;
  logic              rnd_ovf;

  logic is_zero;
  logic do_carry;
  logic do_promo;
  logic do_shl;
  logic do_round;

  assign result  = res_q;
  assign exp_inc = exp_q + EONE;

  // any non-zero payload becomes a quiet NaN
  assign in_frac  = mantissaIn[FRAC_W+1:2];
  assign nan_frac = in_frac
                  | {(|in_frac), {(FRAC_W-1){1'b0}}};

  assign is_zero  = (mant_q == '0);
  assign do_carry = !is_zero && mant_q[CB];
  assign do_promo = !is_zero && !mant_q[CB]
                 && mant_q[HB] && exp_q == '0;
  assign do_shl   = !is_zero && !mant_q[CB]
                 && !mant_q[HB] && exp_q > EONE;
  assign do_round = !(is_zero || do_carry
                   || do_promo || do_shl);

  fp_round u_round (
    .mant     (mant_q),
    .exp      (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .ovf      (rnd_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      res_q    <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          inReady <= 1'b1;
          if (inValid && inReady) begin
            inReady <= 1'b0;
            sign_q  <= signIn;
            exp_q   <= exponentIn;
            mant_q  <= mantissaIn;
            if (exponentIn == EMAX) begin
              res_q    <= {signIn, EMAX, nan_frac};
              overflow <= 1'b0;
              zero     <= 1'b0;
              outValid <= 1'b1;
              state    <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          unique case (1'b1)
            is_zero: begin
              res_q    <= {sign_q, {EXP_W{1'b0}}, FZERO};
              overflow <= 1'b0;
              zero     <= 1'b1;
              outValid <= 1'b1;
              state    <= DONE;
            end
            do_carry: begin
              mant_q <= {1'b0, mant_q[MW-1:2],
                         mant_q[1] | mant_q[0]};
              exp_q  <= exp_inc;
              if (exp_inc == EMAX) begin
                res_q    <= {sign_q, EMAX, FZERO};
                overflow <= 1'b1;
                zero     <= 1'b0;
                outValid <= 1'b1;
                state    <= DONE;
              end
            end
            do_promo: begin
              exp_q <= EONE;
            end
            do_shl: begin
              mant_q <= {mant_q[MW-2:0], 1'b0};
              exp_q  <= exp_q - EONE;
            end
            do_round: begin
              if (!mant_q[HB]) exp_q <= '0;
              state <= ROUND;
            end
          endcase
        end
        ROUND: begin
          res_q    <= {sign_q, rnd_exp, rnd_frac};
          overflow <= rnd_ovf;
          zero     <= (rnd_exp == '0)
                   && (rnd_frac == FZERO);
          outValid <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: vector table, handshake and
// reset sequences, random ops against a value-level model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        signIn = 1'b0;
  logic [7:0]  exponentIn = '0;
  logic [26:0] mantissaIn = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_normalizer dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .signIn     (signIn),
    .exponentIn (exponentIn),
    .mantissaIn (mantissaIn),
    .outValid   (outValid),
    .outReady   (outReady),
    .result     (result),
    .overflow   (overflow),
    .zero       (zero)
  );

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic [31:0] r;
    logic        ov;
    logic        z;
    int          lat;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Value-level reference: leading-one search, bounded
  // shift, then remainder-vs-half rounding.
  function automatic void model(
    input  logic        s,
    input  logic [7:0]  e,
    input  logic [26:0] m_in,
    output logic [31:0] r,
    output logic        ov,
    output logic        z,
    output int          lat);
    longint m, keep, rem;
    int ex, msb, sh;
    logic [22:0] f;
    bit up;
    ov = 1'b0;
    z  = 1'b0;
    if (e == 8'hFF) begin
      f = m_in[24:2];
      if (f != 0) f[22] = 1'b1;
      r = {s, 8'hFF, f};
      lat = 1;
      return;
    end
    if (m_in == 0) begin
      r = {s, 31'b0};
      z = 1'b1;
      lat = 2;
      return;
    end
    m = longint'(m_in);
    ex = int'(e);
    lat = 3;
    if (m >= (64'd1 << 26)) begin
      m = (m >> 1) | (m & 1);
      ex++;
      lat++;
      if (ex == 255) begin
        r = {s, 8'hFF, 23'b0};
        ov = 1'b1;
        lat = 2;
        return;
      end
    end else if (ex == 0 && m >= (64'd1 << 25)) begin
      ex = 1;
      lat++;
    end
    msb = 0;
    for (int i = 0; i < 27; i++)
      if (m[i]) msb = i;
    if (msb < 25) begin
      sh = 25 - msb;
      if (sh > ex - 1) sh = (ex > 1) ? ex - 1 : 0;
      m = m << sh;
      ex -= sh;
      lat += sh;
    end
    if (m < (64'd1 << 25)) ex = 0;
    keep = m >> 2;
    rem = m & 3;
    up = (rem == 3) || (rem == 2 && keep[0]);
    keep += longint'(up);
    if (keep >= (64'd1 << 25)) begin
      keep = keep >> 1;
      ex++;
    end
    if (ex == 0 && keep >= (64'd1 << 23)) ex = 1;
    if (ex >= 255) begin
      r = {s, 8'hFF, 23'b0};
      ov = 1'b1;
    end else begin
      r = {s, ex[7:0], keep[22:0]};
      z = (r[30:0] == 0);
    end
  endfunction

  task automatic run_op(input logic s,
                        input logic [7:0] e,
                        input logic [26:0] m,
                        input int hold,
                        output logic [31:0] r,
                        output logic ov,
                        output logic z,
                        output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(inReady), 32'd1);
    signIn = s;
    exponentIn = e;
    mantissaIn = m;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = result;
    ov = overflow;
    z = zero;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  task automatic check_op(input string tag,
                          input logic [31:0] r,
                          input logic ov,
                          input logic z,
                          input int lat,
                          input logic [31:0] wr,
                          input logic wov,
                          input logic wz,
                          input int wlat);
    chk({tag, "_result"}, r, wr);
    chk({tag, "_ovf"}, 32'(ov), 32'(wov));
    chk({tag, "_zero"}, 32'(z), 32'(wz));
    chk({tag, "_lat"}, 32'(lat), 32'(wlat));
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] r, wr, held, tmp;
    logic ov, z, wov, wz;
    logic stable, seen;
    int lat, wlat, w, sel, n;
    logic [7:0] e;
    logic [26:0] m;

    vecs.push_back('{1'b0, 8'h7F, 27'h4000000,
                     32'h40000000, 1'b0, 1'b0, 4});
    vecs.push_back('{1'b0, 8'h80, 27'h1000000,
                     32'h3F800000, 1'b0, 1'b0, 4});
    vecs.push_back('{1'b0, 8'h7F, 27'h2000002,
                     32'h3F800000, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b0, 8'h7F, 27'h2000006,
                     32'h3F800002, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b0, 8'hFE, 27'h4000000,
                     32'h7F800000, 1'b1, 1'b0, 2});
    vecs.push_back('{1'b1, 8'hFE, 27'h4000000,
                     32'hFF800000, 1'b1, 1'b0, 2});
    vecs.push_back('{1'b1, 8'h40, 27'h0000000,
                     32'h80000000, 1'b0, 1'b1, 2});
    vecs.push_back('{1'b0, 8'hFF, 27'h0000004,
                     32'h7FC00001, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b1, 8'hFF, 27'h0000000,
                     32'hFF800000, 1'b0, 1'b0, 1});
    vecs.push_back('{1'b0, 8'hFE, 27'h3FFFFFE,
                     32'h7F800000, 1'b1, 1'b0, 3});
    vecs.push_back('{1'b0, 8'h00, 27'h0000004,
                     32'h00000001, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b0, 8'h00, 27'h1FFFFFE,
                     32'h00800000, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b0, 8'h00, 27'h2000000,
                     32'h00800000, 1'b0, 1'b0, 4});
    vecs.push_back('{1'b0, 8'h7F, 27'h0000002,
                     32'h33800000, 1'b0, 1'b0, 27});
    vecs.push_back('{1'b0, 8'h03, 27'h0100000,
                     32'h00100000, 1'b0, 1'b0, 5});
    vecs.push_back('{1'b0, 8'h00, 27'h0000002,
                     32'h00000000, 1'b0, 1'b1, 3});
    vecs.push_back('{1'b0, 8'h00, 27'h0000003,
                     32'h00000001, 1'b0, 1'b0, 3});

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(inReady), 32'd0);
    chk("rst_out_valid", 32'(outValid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(inReady), 32'd1);
    chk("idle_out_ready_valid", 32'(outValid), 32'd0);
    outReady = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].e, vecs[i].m, 0,
             r, ov, z, lat);
      check_op($sformatf("vec%0d", i), r, ov, z, lat,
               vecs[i].r, vecs[i].ov, vecs[i].z,
               vecs[i].lat);
    end

    // back-pressure: DONE held while outReady is low
    @(negedge clk);
    signIn = 1'b0;
    exponentIn = 8'h7F;
    mantissaIn = 27'h4000000;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    n = 0;
    while (!outValid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("hold_valid", 32'(outValid), 32'd1);
    held = result;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (result !== held || !outValid || inReady)
        stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    chk("hold_result", result, 32'h40000000);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    chk("release_valid", 32'(outValid), 32'd0);
    chk("release_ready", 32'(inReady), 32'd1);

    // reset during a 10-shift normalization
    @(negedge clk);
    exponentIn = 8'h80;
    mantissaIn = 27'h0008000;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 32'(inReady), 32'd0);
    chk("mid_rst_valid", 32'(outValid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_idle", 32'(inReady), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (outValid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 32'(seen), 32'd0);

    // random operations against the model
    for (int k = 0; k < 250; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 8'h00;
        1: e = 8'h01;
        2: e = 8'hFE;
        3: e = 8'hFF;
        default: e = 8'($urandom_range(2, 253));
      endcase
      w = $urandom_range(0, 27);
      tmp = $urandom;
      tmp = tmp & ((32'd1 << w) - 32'd1);
      m = tmp[26:0];
      model(1'($urandom), e, m, wr, wov, wz, wlat);
      run_op(wr[31], e, m, $urandom_range(0, 2),
             r, ov, z, lat);
      check_op($sformatf("rnd%0d", k), r, ov, z, lat,
               wr, wov, wz, wlat);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
